// File: rtl/async_product_harness.sv
`default_nettype none
// ============================================================================
// Module   : async_product_harness
// Purpose  : Drives N_COPIES code-block copies from one clock with per-copy
//            step enables. Holds all copies for one cycle after reset, grants
//            scheduler stutter requests under a bounded-stutter rule, and
//            checks observation alignment on request (sticky mismatch).
// Revision : 1.0 - initial parametrised release
// ============================================================================
module async_product_harness #(
  parameter int N_COPIES           = 2,
  parameter int OBS_W              = 1,
  parameter int MAX_STUTTER        = 3,
  parameter int FREEZE_ON_MISMATCH = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_COPIES-1:0]       sched_stutter,
  input  logic                      align_req,
  input  logic [N_COPIES*OBS_W-1:0] obs_in,
  output logic [N_COPIES-1:0]       step_en,
  output logic [N_COPIES-1:0]       st_out,
  output logic [N_COPIES-1:0]       forced_step,
  output logic                      started,
  output logic                      aligned,
  output logic                      mismatch
);

  localparam int               CNT_W         = $clog2(MAX_STUTTER + 1);
  localparam logic [CNT_W-1:0] C_MAX_STUTTER = CNT_W'(MAX_STUTTER);
  localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_RUN    = 2'd1,
    S_FROZEN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt [N_COPIES];
  logic                r_aligned;
  logic                r_mismatch;
  logic [N_COPIES-1:0] w_grant_raw;
  logic [N_COPIES-1:0] w_grant;
  logic [N_COPIES-1:0] w_slice_eq;
  logic                w_obs_eq;
  logic                w_check;

  // Per-copy stutter eligibility and comparison of each obs slice to slice 0
  for (genvar gi = 0; gi < N_COPIES; gi++) begin : g_copy
    assign w_grant_raw[gi] = sched_stutter[gi] && (r_cnt[gi] < C_MAX_STUTTER);
    assign w_slice_eq[gi]  = (obs_in[gi*OBS_W +: OBS_W] == obs_in[0 +: OBS_W]);
  end

  assign w_obs_eq = &w_slice_eq;
  assign w_check  = (r_state == S_RUN) && align_req;

  // All-stutter guard: if everyone would stutter, copy 0 is made to step
  always_comb begin
    w_grant = w_grant_raw;
    if (&w_grant_raw) begin
      w_grant[0] = 1'b0;
    end
  end

  // Next-state and per-copy step/stutter outputs
  always_comb begin
    w_state_nxt = r_state;
    step_en     = '0;
    st_out      = '1;
    forced_step = '0;
    case (r_state)
      S_INIT: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        step_en     = ~w_grant;
        st_out      = w_grant;
        forced_step = sched_stutter & ~w_grant;
        if (w_check && !w_obs_eq && (FREEZE_ON_MISMATCH != 0)) begin
          w_state_nxt = S_FROZEN;
        end
      end
      S_FROZEN: begin
        w_state_nxt = S_FROZEN;
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stutter counters: count granted stutters, clear whenever the copy steps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_COPIES; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (r_state == S_RUN) begin
      for (int i = 0; i < N_COPIES; i++) begin
        if (w_grant[i]) begin
          r_cnt[i] <= r_cnt[i] + C_CNT_ONE;
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Alignment flags, only updated on RUN cycles with an alignment request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aligned  <= 1'b0;
      r_mismatch <= 1'b0;
    end else if (w_check) begin
      r_aligned  <= w_obs_eq;
      r_mismatch <= r_mismatch | !w_obs_eq;
    end
  end

  assign started  = (r_state != S_INIT);
  assign aligned  = r_aligned;
  assign mismatch = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_async_product_harness.sv
`default_nettype none
// ============================================================================
// Module   : tb_async_product_harness
// Purpose  : Self-checking bench for async_product_harness. Two instances
//            (2 copies with freeze, 3 copies x 4-bit obs without freeze)
//            are checked every cycle against a behavioural model, plus
//            hand-computed expectations for the directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_async_product_harness;

  localparam int A_N = 2, A_W = 1, A_MAX = 3, A_FRZ = 1;
  localparam int B_N = 3, B_W = 4, B_MAX = 3, B_FRZ = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [A_N-1:0]     a_sched = '0;
  logic               a_align = 1'b0;
  logic [A_N*A_W-1:0] a_obs   = '0;
  logic [A_N-1:0]     a_step, a_st, a_forced;
  logic               a_started, a_aligned, a_mismatch;

  logic [B_N-1:0]     b_sched = '0;
  logic               b_align = 1'b0;
  logic [B_N*B_W-1:0] b_obs   = '0;
  logic [B_N-1:0]     b_step, b_st, b_forced;
  logic               b_started, b_aligned, b_mismatch;

  always #5 clk = ~clk;

  async_product_harness #(
    .N_COPIES(A_N), .OBS_W(A_W), .MAX_STUTTER(A_MAX), .FREEZE_ON_MISMATCH(A_FRZ)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .sched_stutter(a_sched), .align_req(a_align),
    .obs_in(a_obs), .step_en(a_step), .st_out(a_st), .forced_step(a_forced),
    .started(a_started), .aligned(a_aligned), .mismatch(a_mismatch)
  );

  async_product_harness #(
    .N_COPIES(B_N), .OBS_W(B_W), .MAX_STUTTER(B_MAX), .FREEZE_ON_MISMATCH(B_FRZ)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sched_stutter(b_sched), .align_req(b_align),
    .obs_in(b_obs), .step_en(b_step), .st_out(b_st), .forced_step(b_forced),
    .started(b_started), .aligned(b_aligned), .mismatch(b_mismatch)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model per instance: phase 0=init, 1=run, 2=frozen
  int m_phase    [2];
  int m_cnt      [2][8];
  bit m_aligned  [2];
  bit m_mismatch [2];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_phase[k]    = 0;
    m_aligned[k]  = 1'b0;
    m_mismatch[k] = 1'b0;
    for (int i = 0; i < 8; i++) m_cnt[k][i] = 0;
  endtask

  // Compare one instance's outputs for the current cycle, then advance its model
  task automatic model_cycle(
    input int k, input int n, input int maxs, input int frz, input int obsw,
    input logic [7:0] sched, input logic align, input logic [31:0] obs,
    input logic [7:0] step, input logic [7:0] st, input logic [7:0] forced,
    input logic started, input logic aligned, input logic mismatch,
    input string tag);
    logic [7:0] mask, g, e_step, e_st, e_forced;
    bit eq;
    int s0, si;
    mask = 8'((1 << n) - 1);
    g    = '0;
    if (m_phase[k] == 1) begin
      for (int i = 0; i < n; i++)
        if (sched[i] && m_cnt[k][i] < maxs) g[i] = 1'b1;
      if (g == mask) g[0] = 1'b0;
      e_step   = mask & ~g;
      e_st     = g;
      e_forced = sched & mask & ~g;
    end else begin
      e_step   = '0;
      e_st     = mask;
      e_forced = '0;
    end
    chk({tag, ".step_en"},     int'(step),     int'(e_step));
    chk({tag, ".st_out"},      int'(st),       int'(e_st));
    chk({tag, ".forced_step"}, int'(forced),   int'(e_forced));
    chk({tag, ".started"},     int'(started),  (m_phase[k] != 0) ? 1 : 0);
    chk({tag, ".aligned"},     int'(aligned),  int'(m_aligned[k]));
    chk({tag, ".mismatch"},    int'(mismatch), int'(m_mismatch[k]));
    if (m_phase[k] == 0) begin
      m_phase[k] = 1;
    end else if (m_phase[k] == 1) begin
      for (int i = 0; i < n; i++) m_cnt[k][i] = g[i] ? m_cnt[k][i] + 1 : 0;
      if (align) begin
        eq = 1'b1;
        s0 = int'(obs) & ((1 << obsw) - 1);
        for (int i = 1; i < n; i++) begin
          si = int'(obs >> (i * obsw)) & ((1 << obsw) - 1);
          if (si != s0) eq = 1'b0;
        end
        m_aligned[k] = eq;
        if (!eq) begin
          m_mismatch[k] = 1'b1;
          if (frz != 0) m_phase[k] = 2;
        end
      end
    end
  endtask

  // Per-cycle compare of both instances against the model
  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(negedge clk);
      if (!rst_n) begin model_reset(0); model_reset(1); end
      model_cycle(0, A_N, A_MAX, A_FRZ, A_W, 8'(a_sched), a_align, 32'(a_obs),
                  8'(a_step), 8'(a_st), 8'(a_forced), a_started, a_aligned, a_mismatch, "A");
      model_cycle(1, B_N, B_MAX, B_FRZ, B_W, 8'(b_sched), b_align, 32'(b_obs),
                  8'(b_step), 8'(b_st), 8'(b_forced), b_started, b_aligned, b_mismatch, "B");
      if (!rst_n) begin model_reset(0); model_reset(1); end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed scenarios with hand-computed expectations, then random traffic
  initial begin
    logic [31:0] v;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit.init_step", int'(a_step), 0);
    chk("lit.init_started", int'(a_started), 0);
    tick();
    @(negedge clk);
    chk("lit.run_step", int'(a_step), 3);
    chk("lit.run_started", int'(a_started), 1);

    // Copy 0 stutter request held: three stutters then a forced step, repeating
    tick();
    a_sched = 2'b01;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("lit.bounded_step0", int'(a_step[0]), (c % 4 == 3) ? 1 : 0);
      chk("lit.bounded_forced0", int'(a_forced[0]), (c % 4 == 3) ? 1 : 0);
      tick();
    end

    // Both request stutter with counters at 0: copy 0 forced to step
    a_sched = 2'b11;
    @(negedge clk);
    chk("lit.guard_step", int'(a_step), 1);
    chk("lit.guard_forced", int'(a_forced), 1);
    chk("lit.guard_st", int'(a_st), 2);
    tick();

    // Equal observations
    a_sched = 2'b00;
    a_align = 1'b1;
    a_obs   = 2'b11;
    tick();
    a_align = 1'b0;
    @(negedge clk);
    chk("lit.eq_aligned", int'(a_aligned), 1);
    chk("lit.eq_mismatch", int'(a_mismatch), 0);

    // Build stutter count, then unequal sample in the same cycle as a grant
    tick();
    a_sched = 2'b01;
    tick();
    a_align = 1'b1;
    a_obs   = 2'b01;
    @(negedge clk);
    chk("lit.simul_step", int'(a_step), 2);
    tick();
    a_align = 1'b0;
    @(negedge clk);
    chk("lit.neq_aligned", int'(a_aligned), 0);
    chk("lit.neq_mismatch", int'(a_mismatch), 1);
    chk("lit.frozen_step", int'(a_step), 0);
    chk("lit.frozen_st", int'(a_st), 3);
    tick();
    @(negedge clk);
    chk("lit.frozen_step2", int'(a_step), 0);

    // Asynchronous reset while frozen with copy 0 mid-stutter
    tick();
    rst_n = 1'b0;
    #1;
    chk("lit.rst_mismatch", int'(a_mismatch), 0);
    chk("lit.rst_started", int'(a_started), 0);
    chk("lit.rst_step", int'(a_step), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit.rel_started", int'(a_started), 0);
    tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("lit.rel_step0", int'(a_step[0]), (c == 3) ? 1 : 0);
      tick();
    end
    a_sched = 2'b00;

    // No-freeze instance: 5,5,6 then 5,5,5
    b_obs   = 12'h655;
    b_align = 1'b1;
    tick();
    b_align = 1'b0;
    @(negedge clk);
    chk("lit.b_mismatch", int'(b_mismatch), 1);
    chk("lit.b_aligned0", int'(b_aligned), 0);
    chk("lit.b_step", int'(b_step), 7);
    tick();
    b_obs   = 12'h555;
    b_align = 1'b1;
    tick();
    b_align = 1'b0;
    @(negedge clk);
    chk("lit.b_aligned1", int'(b_aligned), 1);
    chk("lit.b_sticky", int'(b_mismatch), 1);
    chk("lit.b_step2", int'(b_step), 7);

    // Random traffic with occasional reset pulses
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < A_N; i++) a_sched[i] = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < B_N; i++) b_sched[i] = ($urandom_range(0, 3) != 0);
      a_align = ($urandom_range(0, 2) == 0);
      b_align = ($urandom_range(0, 2) == 0);
      v = $urandom;
      if ($urandom_range(0, 7) != 0) a_obs = {A_N{v[A_W-1:0]}};
      else                           a_obs = (A_N*A_W)'($urandom);
      v = $urandom;
      if ($urandom_range(0, 7) != 0) b_obs = {B_N{v[B_W-1:0]}};
      else                           b_obs = (B_N*B_W)'($urandom);
    end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/async_product_harness.md
Name: async_product_harness

Overview:
- Parametrised successor to the two-copy product wrapper used for asynchronous HyperLTL checking of compiler optimisations.
- Drives N_COPIES code-block instances (source, target, further variants) from one clock, with per-copy step enables.
- Holds every copy for one initial cycle after reset.
- Enforces a bounded-stutter fairness rule and checks observation alignment on request, flagging divergence as a sticky mismatch.
- Sits between the top-level nondeterministic scheduler inputs and the code-block instances. Flattened to AIGER for model checking.

Parameters:
- N_COPIES, 2, number of code-block copies (2..8).
- OBS_W, 1, width of each copy's observed variable.
- MAX_STUTTER, 3, max consecutive stutter cycles granted per copy (1..15).
- FREEZE_ON_MISMATCH, 1, 1 = all copies stop stepping once mismatch is set.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sched_stutter  input  N_COPIES  bit i = scheduler requests copy i to stutter this cycle.
- align_req  input  1  scheduler asserts that copies should currently agree.
- obs_in  input  N_COPIES*OBS_W  observed variable of copy i at bits [i*OBS_W +: OBS_W].
- step_en  output  N_COPIES  clock/step enable to copy i.
- st_out  output  N_COPIES  copy i is stuttering this cycle (for the property monitor).
- forced_step  output  N_COPIES  copy i's stutter request was denied this cycle.
- started  output  1  harness has left INIT.
- aligned  output  1  registered: last align_req sample had all obs equal.
- mismatch  output  1  sticky: some align_req sample had obs unequal.

Behaviour:
- Clock and reset:
  - Single clock; reset is asynchronous and active-low, ports named clk and rst_n.
  - Asserting rst_n=0 mid-operation returns to INIT immediately. All counters and flags clear; no partial state survives.
- Reset values: state=INIT, started=0, aligned=0, mismatch=0, all stutter counters=0.
- FSM states: INIT, RUN, FROZEN.
  - INIT → RUN unconditionally on the first clk edge after reset release.
  - RUN → FROZEN on the edge where mismatch is set, only if FREEZE_ON_MISMATCH=1. Otherwise stay in RUN.
  - FROZEN is left only by reset.
- Outputs per state (step_en, st_out, forced_step are combinational from state, counters and sched_stutter):
  - INIT: step_en=0, st_out=all ones, forced_step=0, started=0.
  - FROZEN: step_en=0, st_out=all ones, forced_step=0.
  - RUN: started=1.
- Grant rule in RUN, for each copy i:
  - grant_i = sched_stutter[i] && cnt_i < MAX_STUTTER.
  - All-stutter guard: if every grant_i=1, the grant of the lowest-index copy is cleared. At least one copy always steps.
  - st_out[i] = grant_i; step_en[i] = !grant_i; forced_step[i] = sched_stutter[i] && !grant_i.
- Stutter counters: cnt_i is $clog2(MAX_STUTTER+1) bits.
  - On each RUN edge: cnt_i increments when grant_i=1 and clears when step_en[i]=1.
  - Held in INIT and FROZEN.
  - Never exceeds MAX_STUTTER.
- Alignment check, evaluated on the edge of a RUN cycle with align_req=1:
  - eq = all N_COPIES obs slices equal to slice 0.
  - aligned <= eq.
  - mismatch <= mismatch | !eq.
  - With align_req=0: aligned and mismatch hold.
  - No check in INIT or FROZEN.
- Simultaneous events: an align_req with unequal obs in the same cycle as a stutter grant still sets mismatch. The copy's stutter takes effect in that same cycle (step_en is low).
- Latency:
  - step_en, st_out and forced_step: 0 cycles (combinational).
  - aligned and mismatch: 1 cycle after the sampling edge.
- Synthesisable for the yosys flatten/aigmap flow: no latches, no initial blocks, no gated clocks. Copies consume step_en as an enable.

Test Plan:
- Reset release, sched_stutter=0 → cycle 0: step_en=00, started=0. Cycle 1 onward: step_en=11, started=1.
- N_COPIES=2, MAX_STUTTER=3, sched_stutter=01 held → copy 0 stutters 3 cycles. Cycle 4: step_en[0]=1, forced_step[0]=1, cnt_0 back to 0. The 3-stutter pattern then repeats.
- sched_stutter=11 in RUN with counters 0 → step_en=01, forced_step=01, st_out=10.
- align_req=1 with obs=1,1 → aligned=1, mismatch=0 next cycle. Then align_req=1 with obs=1,0 → aligned=0, mismatch=1. FREEZE=1: step_en=00 from the next cycle on.
- FREEZE_ON_MISMATCH=0, N_COPIES=3, OBS_W=4, obs=5,5,6 with align_req → mismatch=1 stays set while copies keep stepping. A later aligned sample (5,5,5) gives aligned=1, mismatch still 1.
- rst_n pulsed low mid-stutter (cnt=2) while FROZEN → immediately: mismatch=0, cnt=0, state=INIT. Next edge: RUN.
